// File: rtl/atm_pkg.sv
// Shared definitions for the ATM secure-room scheduler and the secure-room controller:
// session state encoding and default session limits.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    AUTH,
    IN_USE,
    LOCKOUT
  } state_t;

  localparam int MAX_ATTEMPTS_DEF    = 3;
  localparam int SESSION_TIMEOUT_DEF = 1024;
  localparam int LOCKOUT_CYCLES_DEF  = 256;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the start index,
// wrapping modulo NUM_REQ.
module atm_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  int          cand;
  logic [IW-1:0] cidx;

  // Scan from the farthest offset down so the nearest candidate is the last to win.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    cidx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(start) + off) % NUM_REQ;
      cidx = IW'(cand);
      if (req[cidx]) begin
        valid  = 1'b1;
        idx    = cidx;
        onehot = NUM_REQ'(1) << cidx;
      end
    end
  end

endmodule

// File: rtl/atm_room_access_scheduler.sv
// Round-robin access scheduler for the single-occupancy ATM secure room: grants one
// kiosk at a time, supervises passcode attempts with a session timeout and lockout.
module atm_room_access_scheduler
  import atm_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_ATTEMPTS    = MAX_ATTEMPTS_DEF,
  parameter int SESSION_TIMEOUT = SESSION_TIMEOUT_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int TW              = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic                              pass_ok,
  input  logic                              pass_fail,
  input  logic                              room_exit,
  output logic [NUM_REQ-1:0]                grant,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              room_start,
  output logic                              busy,
  output logic                              alarm,
  output logic                              timeout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int FW = $clog2(MAX_ATTEMPTS + 1);

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IW-1:0]     grant_id_nxt;
  logic              room_start_nxt, busy_nxt, alarm_nxt, timeout_nxt;
  logic [FW-1:0]     fail_nxt, fail_inc;
  logic              go_idle;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;

  // rr_ptr is the next index to favour; starting at 0 gives req[0] top priority after reset.
  atm_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req    (req),
    .start  (rr_ptr),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      rr_ptr     <= '0;
      grant      <= '0;
      grant_id   <= '0;
      room_start <= 1'b0;
      busy       <= 1'b0;
      alarm      <= 1'b0;
      timeout    <= 1'b0;
      fail_count <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant      <= grant_nxt;
      grant_id   <= grant_id_nxt;
      room_start <= room_start_nxt;
      busy       <= busy_nxt;
      alarm      <= alarm_nxt;
      timeout    <= timeout_nxt;
      fail_count <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    rr_ptr_nxt     = rr_ptr;
    grant_nxt      = grant;
    grant_id_nxt   = grant_id;
    room_start_nxt = 1'b0;
    timeout_nxt    = 1'b0;
    fail_nxt       = fail_count;
    fail_inc       = fail_count + FW'(1);
    go_idle        = 1'b0;

    case (state)
      IDLE: begin
        if (arb_valid) begin
          state_nxt      = GRANT;
          grant_nxt      = arb_onehot;
          grant_id_nxt   = arb_idx;
          rr_ptr_nxt     = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
          room_start_nxt = 1'b1;
        end
      end
      GRANT: begin
        state_nxt = AUTH;
        timer_nxt = '0;
        fail_nxt  = '0;
      end
      AUTH: begin
        // A failure always counts; only a lockout-triggering one preempts the other checks.
        timer_nxt = timer + TW'(1);
        if (pass_fail) fail_nxt = fail_inc;
        if (pass_fail && fail_inc == FW'(MAX_ATTEMPTS)) begin
          state_nxt = LOCKOUT;
          timer_nxt = '0;
          grant_nxt = '0;
        end else if (pass_ok && !pass_fail) begin
          state_nxt = IN_USE;
        end else if (timer == TW'(SESSION_TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          go_idle     = 1'b1;
        end else if (!req[grant_id]) begin
          go_idle = 1'b1;
        end
      end
      IN_USE: begin
        if (room_exit) go_idle = 1'b1;
      end
      LOCKOUT: begin
        timer_nxt = timer + TW'(1);
        if (timer == TW'(LOCKOUT_CYCLES - 1)) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      fail_nxt  = '0;
    end

    busy_nxt  = (state_nxt != IDLE);
    alarm_nxt = (state_nxt == LOCKOUT);
  end

endmodule

// File: doc/atm_room_access_scheduler.md
# atm_room_access_scheduler

Arbitrates access to the single-occupancy ATM secure room between several entry kiosks. Grants the room to one requester at a time (round-robin), starts a room session, supervises passcode attempts with a session timeout, and locks the room out after repeated failures. Sits in front of the ATM secure-room controller and consumes its passcode result and exit events.

## Interface
- NUM_REQ, 4: number of entry kiosks (≥2)
- MAX_ATTEMPTS, 3: failed passcode attempts per session before lockout (≥1)
- SESSION_TIMEOUT, 1024: maximum cycles spent in AUTH
- LOCKOUT_CYCLES, 256: cycles spent in LOCKOUT
- TW, 16: timer width; must hold max(SESSION_TIMEOUT, LOCKOUT_CYCLES)
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  level request per kiosk; held while the customer waits or is in session
- pass_ok  in  1  one-cycle pulse: passcode accepted
- pass_fail  in  1  one-cycle pulse: passcode rejected
- room_exit  in  1  one-cycle pulse: occupant left the room
- grant  out  NUM_REQ  one-hot grant to the current session owner
- grant_id  out  clog2(NUM_REQ)  index of the current or last owner
- room_start  out  1  one-cycle pulse: new session begins
- busy  out  1  any state other than IDLE
- alarm  out  1  high throughout LOCKOUT
- timeout  out  1  one-cycle pulse: AUTH session expired
- fail_count  out  clog2(MAX_ATTEMPTS+1)  failures in the current session

## Operation
- All outputs registered. Reset (reset_n=0 at a clock edge): state IDLE, grant=0, grant_id=0, room_start=0, busy=0, alarm=0, timeout=0, fail_count=0, timer=0, RR pointer so that req[0] has highest priority.
- IDLE: if req≠0, pick the first set bit at or after (last grant_id + 1) modulo NUM_REQ; latch grant_id; go to GRANT. Otherwise stay.
- GRANT (1 cycle): room_start=1, grant one-hot, timer=0, fail_count=0; go to AUTH.
- AUTH: timer increments every cycle. Priority per cycle:
  1. pass_fail (including when pass_ok is high in the same cycle; fail wins): fail_count+1; if the new count equals MAX_ATTEMPTS, go to LOCKOUT with timer=0.
  2. pass_ok: go to IN_USE.
  3. timer == SESSION_TIMEOUT-1: timeout pulse; go to IDLE.
  4. req[grant_id]==0 (customer abandoned): go to IDLE.
- Failures below MAX_ATTEMPTS do not reset the timer.
- IN_USE: room_exit goes to IDLE. req changes are ignored. No timeout applies.
- LOCKOUT: alarm=1, grant=0, and req is ignored. When timer == LOCKOUT_CYCLES-1, go to IDLE and clear fail_count.
- Returning to IDLE clears grant, busy, and fail_count. grant_id holds its value for RR fairness.
- pass_ok, pass_fail, and room_exit arriving in states where they have no meaning (IDLE, GRANT, LOCKOUT; room_exit in AUTH) are ignored.
- Reset asserted mid-session aborts immediately to the reset values. No pulse is emitted.

## Timing
- req seen in IDLE at edge k: grant and room_start high in cycle k+1. room_start low from k+2. AUTH begins at k+2.
- AUTH lasts at most SESSION_TIMEOUT cycles. The timeout pulse occurs in the first IDLE cycle, and grant is low in that same cycle.
- The earliest new grant after a return to IDLE comes 1 cycle later. IDLE always lasts at least 1 cycle.
- alarm rises in the cycle after the MAX_ATTEMPTS-th pass_fail and stays high for exactly LOCKOUT_CYCLES cycles.
- An event's effect on state and outputs is visible in the cycle after the event.

## Structure
- Shared package atm_pkg: state encodings (IDLE, GRANT, AUTH, IN_USE, LOCKOUT) and default MAX_ATTEMPTS, SESSION_TIMEOUT, and LOCKOUT_CYCLES constants. Shared with the secure-room controller.
- Sub-module atm_rr_arbiter: combinational round-robin pick from req and the last grant_id. It returns a one-hot value, an index, and a valid flag. The FSM, timer, and fail counter live in the top module.

## Test plan
- Reset, then req=4'b0101: grant=0001 and room_start=1 one cycle later. After pass_ok, then room_exit, the next grant is 0100 (RR advances past 0).
- Granted kiosk, 2×pass_fail then pass_ok: fail_count goes 1, 2, then the state is IN_USE with alarm=0.
- 3×pass_fail: alarm high for exactly 256 cycles with grant=0 and req ignored. Afterwards the state is IDLE and fail_count=0.
- No pass event for 1024 AUTH cycles: one timeout pulse, grant drops, and a waiting req[1] is granted next.
- pass_ok and pass_fail in the same cycle: counted as a failure, and the state stays AUTH (fail_count=1).
- reset_n low during IN_USE: all outputs return to reset values at the next edge, and req[0] has priority afterwards.
